// File: rtl/posit_decode_pipe.sv
// Two-stage posit field extractor: sign/two's-complement/special detect, then regime run, exponent and fraction split.
// Latency 2 cycles; each stage holds until the next one is empty or draining, so back-pressure stalls without loss.
module posit_decode_pipe #(
  parameter int N  = 16,
  parameter int ES = 1,
  localparam int RW = $clog2(N) + 1,
  localparam int SW = RW + ES,
  localparam int FW = N - ES - 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_posit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic                 out_zero,
  output logic                 out_nar,
  output logic signed [RW-1:0] out_regime,
  output logic [ES-1:0]        out_exp,
  output logic signed [SW-1:0] out_scale,
  output logic [FW-1:0]        out_frac
);

  logic         s1_valid, s1_sign, s1_zero, s1_nar;
  logic [N-2:0] s1_body;
  logic         s2_valid;
  logic         s2_adv;
  logic [N-1:0] in_neg;

  assign s2_adv    = ~s2_valid | out_ready;
  assign in_ready  = ~rst & (~s1_valid | s2_adv);
  assign out_valid = s2_valid;
  assign in_neg    = ~in_posit + N'(1);

  logic                 r0, special;
  logic [N-2:0]         inv, rest;
  logic [RW-1:0]        run;
  logic signed [RW-1:0] k;
  logic [ES-1:0]        exp_f;
  logic [FW-1:0]        frac_f;

  // Run length = leading zeros of the body after folding a leading-ones run to zeros.
  always_comb begin
    r0      = s1_body[N-2];
    inv     = r0 ? ~s1_body : s1_body;
    special = s1_zero | s1_nar;
    run     = RW'(N - 1);
    for (int i = 0; i < N - 1; i++) begin
      if (inv[i]) run = RW'(N - 2 - i);
    end
    k      = r0 ? run - RW'(1) : -run;
    rest   = s1_body << (run + RW'(1));
    exp_f  = rest[N-2 -: ES];
    frac_f = rest[N-2-ES -: FW];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_zero    <= 1'b0;
      s1_nar     <= 1'b0;
      s1_body    <= '0;
      s2_valid   <= 1'b0;
      out_sign   <= 1'b0;
      out_zero   <= 1'b0;
      out_nar    <= 1'b0;
      out_regime <= '0;
      out_exp    <= '0;
      out_scale  <= '0;
      out_frac   <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sign <= in_posit[N-1];
          s1_body <= in_posit[N-1] ? in_neg[N-2:0] : in_posit[N-2:0];
          s1_zero <= (in_posit == '0);
          s1_nar  <= in_posit[N-1] & (in_posit[N-2:0] == '0);
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_sign   <= s1_sign;
          out_zero   <= s1_zero;
          out_nar    <= s1_nar;
          out_regime <= special ? '0 : k;
          out_exp    <= special ? '0 : exp_f;
          // k <<< ES leaves the low ES bits clear, so the exponent drops straight in.
          out_scale  <= special ? '0 : {k, exp_f};
          out_frac   <= special ? '0 : frac_f;
        end
      end
    end
  end

endmodule

// File: doc/posit_decode_pipe.md
# posit_decode_pipe

Parametrised, pipelined posit decoder that generalises the fixed 16-bit, es=1 leading-digit detection into a full posit field extractor for any width N and exponent size ES. It accepts one posit per cycle on a valid/ready handshake and emits sign, regime, exponent, combined scale, left-aligned fraction and zero/NaR flags two cycles later. It sits between posit operand registers and the downstream posit arithmetic datapath, and absorbs back-pressure without dropping or duplicating words.

## Interface
- N, 16, posit width in bits; legal range N >= ES+4
- ES, 1, exponent field width; ES >= 1
- Derived: RW = $clog2(N)+1 (signed regime width), SW = RW+ES (signed scale width), FW = N-ES-3 (fraction width)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input word present
- in_ready  out  1  decoder can accept this cycle
- in_posit  in  N  raw posit word
- out_valid  out  1  decoded result present
- out_ready  in  1  consumer accepts this cycle
- out_sign  out  1  posit sign bit
- out_zero  out  1  input was all zeros
- out_nar  out  1  input was 1 followed by N-1 zeros (NaR)
- out_regime  out  RW  signed regime value k
- out_exp  out  ES  exponent field, zero-padded if truncated
- out_scale  out  SW  signed k*2^ES + exp
- out_frac  out  FW  fraction bits after exponent, left-aligned, zero-padded; hidden bit not included

## Operation
- Stage 1 (register S1): capture sign s = in_posit[N-1]; body = s ? two's-complement(in_posit)[N-2:0] : in_posit[N-2:0]; detect zero and NaR on raw word.
- Stage 2 (register S2): leading-run detection on body. r0 = body[N-2]; m = count of consecutive bits equal to r0 starting at MSB (1..N-1). k = r0 ? m-1 : -m. Range: -(N-2)..(N-2) for non-special inputs.
- Regime occupies m+1 bits (run + terminator); if m = N-1 there is no terminator. Remaining bits shifted to MSB: first ES bits -> out_exp, next FW bits -> out_frac; bits shifted past LSB read as 0.
- out_scale = (k <<< ES) + out_exp, sign-extended to SW.
- Zero input: out_zero=1, out_sign=0, regime/exp/scale/frac = 0. NaR: out_nar=1, out_sign=1, regime/exp/scale/frac = 0. out_zero and out_nar never both 1.
- Handshake: word accepted when in_valid & in_ready; delivered when out_valid & out_ready. Each stage holds its contents until the next stage can take them; a stage advances when downstream is empty or draining in the same cycle.
- in_ready = ~S1_valid | (S1 advances this cycle); combinational from out_ready, no combinational path from in_valid to in_ready.

## Timing
- Latency: word accepted at cycle t appears on outputs at t+2 when out_ready stays high. Throughput 1 word/cycle sustained.
- While out_valid & ~out_ready: all out_* stable; S1 may still fill once; in_ready drops when both stages full.
- Simultaneous accept and deliver with pipe full: both occur, no bubble, no loss.
- Reset: while rst high and the cycle after reset releases for outputs, out_valid=0, in_ready=0 during rst, all out_* = 0; both stage valids cleared. rst asserted mid-stream discards in-flight words; no word emitted after reset that was accepted before it.
- in_ready = 1 in first cycle after rst deasserts.

## Test plan
- N=16,ES=1, out_ready=1, inputs 0x4000, 0x5000, 0x4800, 0xC000 back-to-back -> from cycle t+2 consecutive outputs: (s0,k0,e0,scale0,frac0x000), (s0,k0,e1,scale1,frac0x000), (s0,k0,e0,scale0,frac0x800), (s1,k0,e0,scale0,frac0x000).
- Extremes: 0x7FFF -> k=14, exp=0, scale=28, frac=0; 0x0001 -> k=-14, exp=0, scale=-28, frac=0; 0x0000 -> out_zero=1; 0x8000 -> out_nar=1, out_sign=1.
- Back-pressure: stream 8 random words, hold out_ready=0 for 5 cycles mid-stream -> in_ready low after pipe fills, outputs stable, all 8 words delivered in order, none duplicated.
- Reset mid-stream: assert rst for 1 cycle with both stages valid -> next cycle out_valid=0, all outputs 0, in_ready=1; next accepted word emerges 2 cycles later.
- Parameter sweep N=8 ES=1, N=32 ES=2: exhaustive (N=8) / 10k random (N=32) against reference model of the field rules above; zero mismatches.
